fetch_pc_unit: RTL
==================

# fetch_pc_unit

Instruction-fetch front end of the pipelined CPU. It owns the program counter and applies the `npc_sel` redirect produced by the EX-stage branch comparator (00 sequential, 01 branch/jal taken, 10 jalr). It issues requests to the instruction memory over a req/ready handshake, and buffers returned instructions in a one-entry skid so hazard stalls do not lose data. It produces the IF→ID instruction stream and the flush pulses for the IF/ID and ID/EX registers.

## Interface
- `RESET_PC`, default 32'h0040_0000, PC loaded on reset.
- `clk` input 1 — single clock, rising edge.
- `rstn` input 1 — reset, asynchronous, active-low.
- `npc_sel` input 2 — from EX branch unit: 00 pc+4, 01 take `br_target`, 10 take `jalr_target`, 11 treated as 00.
- `br_target` input 32 — EX-computed pc+imm for taken branch / jal.
- `jalr_target` input 32 — EX-computed rs1+imm; bit 0 forced to 0 on use.
- `stall_if` input 1 — hazard unit: IF output must hold this cycle.
- `imem_req` output 1 — fetch request, registered.
- `imem_addr` output 32 — fetch address, registered, stable while `imem_req`=1.
- `imem_ready` input 1 — one-cycle completion pulse; `imem_rdata` valid with it.
- `imem_rdata` input 32 — fetched instruction.
- `if_valid` output 1 — `if_pc`/`if_inst` hold a valid instruction.
- `if_pc` output 32, `if_inst` output 32 — instruction to IF/ID.
- `flush_id` output 1, `flush_ex` output 1 — combinational, =1 when `npc_sel` is 01 or 10.

## Operation
- Redirect (`npc_sel`∈{01,10}): target = `br_target` or {`jalr_target`[31:1],1'b0}. The redirect wins over `stall_if` and over everything else in the same cycle.
- On a redirect edge: `pc`←target; `if_valid`←0; skid emptied.
- FSM states: IDLE (no request outstanding), WAIT (request outstanding, data wanted), DROP (request outstanding, data to discard).
- IDLE→WAIT when no redirect, `stall_if`=0 and skid empty; on that edge `imem_req`←1 and `imem_addr`←`pc`.
- IDLE with redirect: stay IDLE, `pc`←target.
- WAIT, `imem_ready`=0, redirect: →DROP. A request cannot be withdrawn; `imem_req` stays 1.
- WAIT, `imem_ready`=1, no redirect: instruction accepted; `pc`←`imem_addr`+4; →IDLE; `imem_req`←0.
- WAIT, `imem_ready`=1 with redirect: data discarded; →IDLE; `pc`←target.
- DROP, `imem_ready`=1: data discarded; →IDLE. `pc` already holds the target. A second redirect while in DROP updates `pc` only.
- Accepted data placement:
  - `if_valid`=0, or `stall_if`=0 (the current output is consumed this edge): data goes to `if_*`.
  - Otherwise: data goes to the skid.
- When `stall_if`=0 and the skid is full: skid→`if_*`, skid emptied.
- When `stall_if`=0, the skid is empty and nothing is accepted: `if_valid`←0.
- At most one request is outstanding at any time. The skid never overflows, because no request issues while the skid is full.
- PC arithmetic is mod 2^32: 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: `pc`=`RESET_PC`, state IDLE, `imem_req`=0, `imem_addr`=0, `if_valid`=0, `if_pc`=0, `if_inst`=0, skid empty.
- Flush outputs follow `npc_sel` combinationally, so they are 0 during reset unless `npc_sel` is nonzero.
- First edge after `rstn` rises: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Latency: `imem_ready` edge → `if_valid`=1 on that same edge (registered). Next request issues on the following edge.
- With a zero-wait memory, throughput is one instruction per 2 cycles.
- A redirect in cycle N sets `flush_*`=1 in cycle N only. The target request issues at edge N+1 if IDLE, or one edge after the pending `imem_ready` if in DROP.
- Asynchronous reset mid-request returns to IDLE immediately. A late `imem_ready` that then arrives in IDLE is ignored.

## Test plan
- Reset then a zero-wait memory returning `imem_rdata`=addr^32'hA5A5_A5A5 → requests at 0x00400000, 0x00400004, 0x00400008. `if_pc` follows the same sequence; `if_valid` is 1 for one cycle after each ready.
- A 3-cycle-latency memory with `npc_sel`=01 and `br_target`=0x00400100 asserted during WAIT → FSM enters DROP, the returned data never reaches `if_*`, and the next `imem_addr`=0x00400100. `flush_id`=`flush_ex`=1 for that single cycle.
- `npc_sel`=10, `jalr_target`=0x00400123, coincident with `imem_ready` → data discarded; next `imem_addr`=0x00400122.
- `stall_if` held high for 4 cycles while one instruction is in `if_*` and a second returns → the second lands in the skid and no new `imem_req` issues. After release, `if_*` shows the second instruction in the next cycle, in order, with none lost.
- Redirect plus `stall_if` in the same cycle → redirect taken, `if_valid`=0, skid cleared.
- `RESET_PC`=32'hFFFF_FFFC → the second request address is 0x00000000; `rstn` pulsed low mid-WAIT → `imem_req`=0 and `if_valid`=0 immediately.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// fetch_pc_unit
// ----------------------------------------------------------------------------
// Instruction-fetch front end. It owns the program counter, applies redirects
// from the EX-stage branch unit, issues single outstanding requests to the
// instruction memory and presents fetched instructions to the IF/ID register.
// A one-entry skid buffer keeps a returning instruction from being lost while
// the IF output is held by a hazard stall.
//
// Ports
//   clk          : single clock, rising edge
//   rstn         : asynchronous active-low reset
//   npc_sel      : 00 pc+4, 01 br_target, 10 jalr_target, 11 same as 00
//   br_target    : taken branch / jal target from EX
//   jalr_target  : jalr target from EX (bit 0 cleared on use)
//   stall_if     : hazard unit asks the IF output to hold this cycle
//   imem_req     : registered fetch request
//   imem_addr    : registered fetch address, stable while imem_req=1
//   imem_ready   : one-cycle completion pulse, imem_rdata valid with it
//   imem_rdata   : fetched instruction word
//   if_valid     : if_pc/if_inst hold a valid instruction
//   if_pc        : PC of the instruction presented to IF/ID
//   if_inst      : instruction presented to IF/ID
//   flush_id     : combinational flush of IF/ID on a redirect
//   flush_ex     : combinational flush of ID/EX on a redirect
// ============================================================================
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] br_target,
    input  logic [31:0] jalr_target,
    input  logic        stall_if,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        flush_id,
    output logic        flush_ex
);

    // IDLE: nothing outstanding. WAIT: request outstanding, data wanted.
    // DROP: request outstanding but a redirect made its data stale.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DROP = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic        accept;

    // Only 01 and 10 redirect; 11 behaves like sequential fetch.
    assign redirect        = (npc_sel == 2'b01) || (npc_sel == 2'b10);
    assign redirect_target = (npc_sel == 2'b10) ? {jalr_target[31:1], 1'b0}
                                                : br_target;

    // Returned data is kept only if it is still wanted and no redirect
    // lands in the same cycle.
    assign accept = (state_q == WAIT) && imem_ready && !redirect;

    assign flush_id  = redirect;
    assign flush_ex  = redirect;
    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;

    // State register for the request FSM, PC and output/skid buffers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= 32'h0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= 32'h0;
            if_inst_q    <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'h0;
            skid_inst_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            imem_req_q   <= imem_req_d;
            imem_addr_q  <= imem_addr_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_inst_q    <= if_inst_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
        end
    end

    // Request FSM and PC update. A request can never be withdrawn, so a
    // redirect while waiting moves to DROP and keeps imem_req high until the
    // memory answers; the PC already points at the target by then.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;

        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = redirect_target;
                end else if (!stall_if && !skid_valid_q) begin
                    state_d     = WAIT;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_q;
                end
            end
            WAIT: begin
                if (imem_ready) begin
                    state_d    = IDLE;
                    imem_req_d = 1'b0;
                    pc_d       = redirect ? redirect_target
                                          : (imem_addr_q + 32'd4);
                end else if (redirect) begin
                    state_d = DROP;
                    pc_d    = redirect_target;
                end
            end
            DROP: begin
                if (redirect) begin
                    pc_d = redirect_target;
                end
                if (imem_ready) begin
                    state_d    = IDLE;
                    imem_req_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    // Output and skid management. The IF output is considered consumed on
    // any edge where stall_if is low, so new data may overwrite it then;
    // otherwise accepted data parks in the skid until the stall releases.
    always_comb begin
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_inst_d    = if_inst_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;

        if (redirect) begin
            if_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            if (!if_valid_q || !stall_if) begin
                if_valid_d = 1'b1;
                if_pc_d    = imem_addr_q;
                if_inst_d  = imem_rdata;
            end else begin
                skid_valid_d = 1'b1;
                skid_pc_d    = imem_addr_q;
                skid_inst_d  = imem_rdata;
            end
        end else if (!stall_if) begin
            if (skid_valid_q) begin
                if_valid_d   = 1'b1;
                if_pc_d      = skid_pc_q;
                if_inst_d    = skid_inst_q;
                skid_valid_d = 1'b0;
            end else begin
                if_valid_d = 1'b0;
            end
        end
    end

endmodule
